// File: rtl/fft_64_out_reorder_pkg.sv
// Shared constants, index types and the base-4 digit reversal used by the
// 64-point FFT output reorder buffer.
package fft_64_out_reorder_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int LANES       = 4;
    localparam int FRAME_BEATS = 16;
    localparam int RAM_DEPTH   = 2 * FRAME_BEATS;
    localparam int RAM_AW      = 5;

    typedef logic [3:0] beat_t;
    typedef logic [1:0] lane_t;
    typedef logic [5:0] bin_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_DRAIN = 1'b1
    } rd_state_t;

    // Swap the outer base-4 digits of a 6-bit bin index: {d2,d1,d0} -> {d0,d1,d2}.
    // The mapping is its own inverse.
    function automatic bin_t digitrev4(input bin_t n);
        return {n[1:0], n[3:2], n[5:4]};
    endfunction

endpackage

// File: rtl/fft_64_out_reorder_bank_ram.sv
// One bank of the reorder buffer: simple dual-port RAM with a single write
// port and a registered (1-cycle) read port. Contents are not reset.
module reorder_bank_ram
    import fft_64_out_reorder_pkg::*;
#(
    parameter int WIDTH = 2 * DATA_WIDTH,
    parameter int DEPTH = RAM_DEPTH,
    parameter int AW    = RAM_AW
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; a same-cycle write to the same address returns old data.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_64_out_reorder.sv
// Reorders 64-point FFT frames from base-4 digit-reversed order (4 lanes x
// 16 beats) into natural bin order through a 4-bank ping-pong buffer.
//
// Write FSM
//   state  | meaning
//   W_IDLE | waiting for ctrl_in to mark beat 0 of a frame
//   W_FILL | writing beats 1..15 of the current half
// Read FSM
//   state   | meaning
//   R_IDLE  | nothing to drain
//   R_DRAIN | reading one natural-order beat per cycle from the filled half
//
// Input (b,j) lands in bank (j+b[3:2]) mod 4 at {half,b}; output (m,l) is
// read from bank (m[3:2]+l) mod 4 at {half,l,m[1:0]}. Each cycle touches
// every bank exactly once on both sides, so no bank conflicts arise.
module fft_64_out_reorder #(
    parameter int DATA_WIDTH  = fft_64_out_reorder_pkg::DATA_WIDTH,
    parameter int FRAME_BEATS = fft_64_out_reorder_pkg::FRAME_BEATS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] x_a_in,
    input  logic [DATA_WIDTH-1:0] y_a_in,
    input  logic [DATA_WIDTH-1:0] x_b_in,
    input  logic [DATA_WIDTH-1:0] y_b_in,
    input  logic [DATA_WIDTH-1:0] x_c_in,
    input  logic [DATA_WIDTH-1:0] y_c_in,
    input  logic [DATA_WIDTH-1:0] x_d_in,
    input  logic [DATA_WIDTH-1:0] y_d_in,
    input  logic                  ctrl_in,
    output logic [DATA_WIDTH-1:0] x_a_out,
    output logic [DATA_WIDTH-1:0] y_a_out,
    output logic [DATA_WIDTH-1:0] x_b_out,
    output logic [DATA_WIDTH-1:0] y_b_out,
    output logic [DATA_WIDTH-1:0] x_c_out,
    output logic [DATA_WIDTH-1:0] y_c_out,
    output logic [DATA_WIDTH-1:0] x_d_out,
    output logic [DATA_WIDTH-1:0] y_d_out,
    output logic                  ctrl_out,
    output logic                  valid_out
);

    import fft_64_out_reorder_pkg::*;

    localparam int    SW        = 2 * DATA_WIDTH;
    localparam beat_t LAST_BEAT = beat_t'(FRAME_BEATS - 1);

    typedef logic [SW-1:0] sample_t;

    // Lane-ordered input samples and bank-ordered buffer traffic.
    sample_t           lane_in    [LANES];
    sample_t           bank_wdata [LANES];
    sample_t           bank_rdata [LANES];
    logic [RAM_AW-1:0] bank_raddr [LANES];
    logic [RAM_AW-1:0] bank_waddr;
    sample_t           out_lane   [LANES];

    // Write side.
    wr_state_t wr_state;
    wr_state_t wr_state_nxt;
    beat_t     wcnt;
    beat_t     wr_beat;
    logic      wr_en;
    logic      frame_done;
    logic      wp;
    logic      rp;
    logic      start_rd;

    // Read side.
    rd_state_t rd_state;
    rd_state_t rd_state_nxt;
    beat_t     rcnt;
    beat_t     rcnt_nxt;
    logic      rd_en;
    logic      rd_half;

    // Pipeline stage aligned with the bank read data.
    logic      valid_q;
    logic      first_q;
    lane_t     rot_q;

    assign lane_in[0] = {x_a_in, y_a_in};
    assign lane_in[1] = {x_b_in, y_b_in};
    assign lane_in[2] = {x_c_in, y_c_in};
    assign lane_in[3] = {x_d_in, y_d_in};

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------

    // Write FSM state and write-side bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= W_IDLE;
            wcnt     <= '0;
            wp       <= 1'b0;
            rp       <= 1'b0;
            start_rd <= 1'b0;
        end else begin
            wr_state <= wr_state_nxt;
            start_rd <= frame_done;
            if (wr_en) begin
                wcnt <= beat_t'(wr_beat + 4'd1);
            end
            if (frame_done) begin
                rp <= wp;
                wp <= ~wp;
            end
        end
    end

    // Write FSM next state; ctrl_in mid-frame restarts the same half.
    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            W_IDLE: begin
                if (ctrl_in) begin
                    wr_state_nxt = W_FILL;
                end
            end
            W_FILL: begin
                if (!ctrl_in && (wcnt == LAST_BEAT)) begin
                    wr_state_nxt = W_IDLE;
                end
            end
        endcase
    end

    // Write FSM outputs: which beat is written this cycle and frame completion.
    always_comb begin
        wr_en      = 1'b0;
        wr_beat    = '0;
        frame_done = 1'b0;
        case (wr_state)
            W_IDLE: begin
                wr_en = ctrl_in;
            end
            W_FILL: begin
                wr_en = 1'b1;
                if (!ctrl_in) begin
                    wr_beat    = wcnt;
                    frame_done = (wcnt == LAST_BEAT);
                end
            end
        endcase
    end

    // Write rotator: bank i takes lane (i - b[3:2]) mod 4.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            bank_wdata[i] = lane_in[lane_t'(lane_t'(i) - wr_beat[3:2])];
        end
    end

    assign bank_waddr = {wp, wr_beat};

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------

    // Read FSM state, beat counter and the half being drained. The half is
    // latched on start so a back-to-back frame flipping rp cannot disturb
    // the last beat of the current drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= R_IDLE;
            rcnt     <= '0;
            rd_half  <= 1'b0;
        end else begin
            rd_state <= rd_state_nxt;
            rcnt     <= rcnt_nxt;
            if (start_rd) begin
                rd_half <= rp;
            end
        end
    end

    // Read FSM next state and beat counter.
    always_comb begin
        rd_state_nxt = rd_state;
        rcnt_nxt     = '0;
        case (rd_state)
            R_IDLE: begin
                if (start_rd) begin
                    rd_state_nxt = R_DRAIN;
                end
            end
            R_DRAIN: begin
                if (start_rd) begin
                    rcnt_nxt = '0;
                end else begin
                    rcnt_nxt = beat_t'(rcnt + 4'd1);
                    if (rcnt == LAST_BEAT) begin
                        rd_state_nxt = R_IDLE;
                    end
                end
            end
        endcase
    end

    // Read FSM outputs: a bank read is issued every draining cycle.
    always_comb begin
        rd_en = 1'b0;
        case (rd_state)
            R_IDLE:  rd_en = 1'b0;
            R_DRAIN: rd_en = 1'b1;
        endcase
    end

    // Read addresses: bank i serves output lane l = (i - m[3:2]) mod 4.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            bank_raddr[i] = {rd_half, lane_t'(lane_t'(i) - rcnt[3:2]), rcnt[1:0]};
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_bank
        reorder_bank_ram #(
            .WIDTH (SW),
            .DEPTH (RAM_DEPTH),
            .AW    (RAM_AW)
        ) u_bank (
            .clk     (clk),
            .wr_en   (wr_en),
            .wr_addr (bank_waddr),
            .wr_data (bank_wdata[g]),
            .rd_en   (rd_en),
            .rd_addr (bank_raddr[g]),
            .rd_data (bank_rdata[g])
        );
    end

    // ------------------------------------------------------------------
    // Output pipeline
    // ------------------------------------------------------------------

    // Carry beat qualifiers alongside the bank read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            first_q <= 1'b0;
            rot_q   <= '0;
        end else begin
            valid_q <= rd_en;
            first_q <= rd_en && (rcnt == '0);
            rot_q   <= rcnt[3:2];
        end
    end

    // Un-rotate into natural lane order; data holds between frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            ctrl_out  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                out_lane[i] <= '0;
            end
        end else begin
            valid_out <= valid_q;
            ctrl_out  <= first_q;
            if (valid_q) begin
                for (int i = 0; i < LANES; i++) begin
                    out_lane[i] <= bank_rdata[lane_t'(lane_t'(i) + rot_q)];
                end
            end
        end
    end

    assign x_a_out = out_lane[0][SW-1:DATA_WIDTH];
    assign y_a_out = out_lane[0][DATA_WIDTH-1:0];
    assign x_b_out = out_lane[1][SW-1:DATA_WIDTH];
    assign y_b_out = out_lane[1][DATA_WIDTH-1:0];
    assign x_c_out = out_lane[2][SW-1:DATA_WIDTH];
    assign y_c_out = out_lane[2][DATA_WIDTH-1:0];
    assign x_d_out = out_lane[3][SW-1:DATA_WIDTH];
    assign y_d_out = out_lane[3][DATA_WIDTH-1:0];

endmodule

// File: doc/fft_64_out_reorder.md
Name: fft_64_out_reorder

Overview:
- Sits directly downstream of the 64-point streaming FFT core, which emits 4 complex samples per clock over 16 beats in base-4 digit-reversed bin order.
- Rewrites each frame into natural bin order using a conflict-free 4-bank ping-pong buffer.
- Streams at full rate, so frames may arrive back to back.
- Marks frames with the same one-cycle start pulse convention used by the FFT core.

Parameters:
DATA_WIDTH, 16, width of each real/imag component
FRAME_BEATS, 16, beats per 64-point frame (fixed; 4 lanes x 16 = 64)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
x_a_in,y_a_in,x_b_in,y_b_in,x_c_in,y_c_in,x_d_in,y_d_in  in  DATA_WIDTH each  lanes a..d (lane index j=0..3) real/imag, FFT order
ctrl_in  in  1  one-cycle pulse coincident with beat 0 of a frame
x_a_out..y_d_out (8 ports)  out  DATA_WIDTH each  lanes a..d, natural order
ctrl_out  out  1  one-cycle pulse coincident with output beat 0
valid_out  out  1  high for the 16 output beats of a frame

Behaviour:
- Reset:
  - all data outputs 0; ctrl_out=0; valid_out=0.
  - write FSM to W_IDLE; read FSM to R_IDLE; write half wp=0.
  - buffer contents are don't-care.
- Order mapping:
  - input beat b, lane j carries bin k = digitrev4(4b+j), where digitrev4 swaps base-4 digits d2,d0.
  - output beat m, lane l carries bin 4m+l.
  - equivalently, output (m,l) = input (beat 4l+m[1:0], lane m[3:2]).
- Banking (4 banks; depth 32 = 2 halves x 16; width 2*DATA_WIDTH, {x,y}):
  - write: input lane j goes to bank (j+b[3:2]) mod 4, address {wp,b}.
  - read: output lane l comes from bank (m[3:2]+l) mod 4, address {rp,4l+m[1:0]}.
  - a write rotator and a read un-rotator steer the data; no bank conflicts occur.
- Write FSM:
  - W_IDLE: ctrl_in=1 writes beat 0, wcnt<=1, go to W_FILL.
  - W_FILL: each cycle writes beat wcnt and increments wcnt.
  - On writing beat 15: rp<=wp, wp<=~wp, pulse start_rd, go to W_IDLE.
  - If ctrl_in=1 coincides with that last beat's completion, it is the next frame's beat 0 and is written into the new half (back-to-back frames).
  - ctrl_in=1 while in W_FILL with wcnt!=0: partial frame discarded; that input is beat 0 of the same half; wcnt<=1; no start_rd.
- Read FSM:
  - R_IDLE: on start_rd go to R_DRAIN with rcnt=0.
  - R_DRAIN: issue one read beat per cycle, rcnt 0..15; after 15 return to R_IDLE, unless start_rd is present, in which case restart at 0.
- Timing and latency:
  - banks use synchronous read, 1 cycle; output registers add 1 more.
  - ctrl_in sampled at edge E0 → beat 15 at E15 → read beat 0 address at E16 → ctrl_out=1 and beat 0 on the outputs after E18.
  - fixed latency of 18 cycles from ctrl_in to ctrl_out.
  - valid_out high for exactly 16 consecutive cycles per completed frame.
- Hazards and gaps:
  - half rp is never overwritten before its drain ends, since the next write to it begins ≥16 cycles after the drain starts.
  - inputs between frames (W_IDLE, no ctrl_in) are ignored.
  - outputs hold their last values while valid_out=0.
- Reset mid-operation: both FSMs abort immediately; no ctrl_out/valid_out for in-flight frames; the next frame after reset behaves normally.
- Width: data passes unmodified; no arithmetic or saturation.

Decomposition:
- Shared package:
  - DATA_WIDTH, LANES=4, FRAME_BEATS=16.
  - beat/lane index typedefs.
  - digitrev4 function, reused by the bench reference model.
- One sub-module: reorder_bank_ram, a simple dual-port RAM, 32 x 2*DATA_WIDTH, one write port and one registered read port, instantiated 4×.
- Rotators and FSMs stay in the top block.

Test Plan:
- Index frame: beat b lane j drives x=4b+j, y=~(4b+j) → out beat0 x={0,16,32,48}, beat1 x={4,20,36,52}, beat15 x={15,31,47,63}, y matching; ctrl_out exactly 18 cycles after ctrl_in; valid_out high 16 cycles.
- Back-to-back frames: ctrl_in at cycles 0,16,32 with values offset +100 per frame → three contiguous 48-beat output runs, ctrl_out at 18,34,50, no data corruption.
- Gap between frames: second ctrl_in at cycle 40 → second ctrl_out at 58; valid_out low for cycles 34..57; outputs hold frame-1 beat 15 values.
- Aborted frame: ctrl_in at 0, again at 7, then 16 beats → single ctrl_out at 25 carrying the second frame only; no output from the partial frame.
- Reset mid-drain: rst=1 at cycle 22 for 2 cycles → valid_out=0, ctrl_out=0, data outputs 0 from cycle 23; new frame with ctrl_in at 30 → ctrl_out at 48, correct ordering.
- Random data over 200 frames compared against a digitrev4 reference model → zero mismatches.
